// File: rtl/task_dispatcher_if.sv
// Op bus, sorter words and host handshake shared between task_dispatcher and its tasks/host.
// The dispatcher side uses the master modport; tasks and host drive through slave.
interface task_dispatcher_if #(
   parameter int N_TASKS = 8
);
   logic [8*N_TASKS-1:0] sorter_in;
   logic [N_TASKS-1:0]   exe_flag;
   logic [15:0]          host_op;
   logic                 host_valid;
   logic                 host_ready;
   logic [15:0]          op_out;
   logic                 op_valid;
   logic [3:0]           cur_task;
   logic                 busy;
   logic [7:0]           err_cnt;

   modport master (
      input  sorter_in, exe_flag, host_op, host_valid,
      output host_ready, op_out, op_valid, cur_task, busy, err_cnt
   );

   modport slave (
      output sorter_in, exe_flag, host_op, host_valid,
      input  host_ready, op_out, op_valid, cur_task, busy, err_cnt
   );
endinterface

// File: rtl/task_dispatcher.sv
// Picks the highest-priority ready task, issues Execute, waits for its ack, runs a time slice,
// then issues Finish; forwards host op words while idle. Optional: DISPATCH_ROUND_ROBIN_EN.
module task_dispatcher #(
   parameter int N_TASKS      = 8,
   parameter int SLICE_CYCLES = 1000,
   parameter int ACK_TIMEOUT  = 64
) (
   input  logic              CLK,
   input  logic              RST,
   task_dispatcher_if.master bus
);
   localparam int IDX_W   = (N_TASKS > 1) ? $clog2(N_TASKS) : 1;
   localparam int SLICE_W = $clog2(SLICE_CYCLES);
   localparam int ACK_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   localparam logic [SLICE_W-1:0] SLICE_LAST = SLICE_W'(SLICE_CYCLES - 1);
   localparam logic [ACK_W-1:0]   ACK_LAST   = ACK_W'(ACK_TIMEOUT - 1);
   localparam logic [3:0]         OP_EXECUTE = 4'h7;
   localparam logic [3:0]         OP_FINISH  = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE, S_SEL, S_EXE, S_ACK, S_RUN, S_FIN
   } state_e;

   state_e             state_q;
   logic [IDX_W-1:0]   idx_q;
   logic [3:0]         id_q;
   logic [SLICE_W-1:0] slice_cnt_q;
   logic [ACK_W-1:0]   ack_cnt_q;
   logic [15:0]        op_out_q;
   logic               op_valid_q;
   logic [3:0]         cur_task_q;
   logic               busy_q;
   logic [7:0]         err_cnt_q;

   logic [IDX_W-1:0]   start_idx;
   logic               win_found_d;
   logic [IDX_W-1:0]   win_idx_d;
   logic [3:0]         win_id_d;
   logic [3:0]         win_prio_d;

`ifdef DISPATCH_ROUND_ROBIN_EN
   logic [IDX_W-1:0]   last_idx_q;

   assign start_idx = (int'(last_idx_q) == N_TASKS - 1) ? '0 : last_idx_q + 1'b1;
`else
   assign start_idx = '0;
`endif

   // Scan slots starting at start_idx; strict '>' keeps the first slot met on a priority tie.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path leaves it
      // unassigned and no latch is inferred.
      win_found_d = 1'b0;
      win_idx_d   = '0;
      win_id_d    = '0;
      win_prio_d  = '0;
      for (int k = 0; k < N_TASKS; k++) begin
         int slot;
         slot = int'(start_idx) + k;
         if (slot >= N_TASKS) slot = slot - N_TASKS;
         if (bus.sorter_in[8*slot +: 8] != 8'h00 &&
             (!win_found_d || bus.sorter_in[8*slot +: 4] > win_prio_d)) begin
            win_found_d = 1'b1;
            win_idx_d   = IDX_W'(slot);
            win_id_d    = bus.sorter_in[8*slot+4 +: 4];
            win_prio_d  = bus.sorter_in[8*slot +: 4];
         end
      end
   end

   // NOTE: state and registered outputs use non-blocking assignments so every register samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         id_q        <= '0;
         slice_cnt_q <= '0;
         ack_cnt_q   <= '0;
         op_out_q    <= '0;
         op_valid_q  <= 1'b0;
         cur_task_q  <= '0;
         busy_q      <= 1'b0;
         err_cnt_q   <= '0;
`ifdef DISPATCH_ROUND_ROBIN_EN
         last_idx_q  <= IDX_W'(N_TASKS - 1);
`endif
      end else begin
         op_valid_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (bus.host_valid) begin
                  op_out_q   <= bus.host_op & 16'h0FFF;
                  op_valid_q <= 1'b1;
               end else if (|bus.sorter_in) begin
                  busy_q  <= 1'b1;
                  state_q <= S_SEL;
               end
            end
            S_SEL: begin
               if (win_found_d) begin
                  idx_q      <= win_idx_d;
                  id_q       <= win_id_d;
                  op_out_q   <= {4'h0, win_id_d, OP_EXECUTE, 4'h0};
                  op_valid_q <= 1'b1;
                  state_q    <= S_EXE;
`ifdef DISPATCH_ROUND_ROBIN_EN
                  last_idx_q <= win_idx_d;
`endif
               end else begin
                  // Every slot dropped between detection and selection.
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            S_EXE: begin
               ack_cnt_q  <= '0;
               cur_task_q <= id_q;
               state_q    <= S_ACK;
            end
            S_ACK: begin
               if (bus.exe_flag[idx_q]) begin
                  slice_cnt_q <= '0;
                  state_q     <= S_RUN;
               end else if (ack_cnt_q == ACK_LAST) begin
                  if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                  cur_task_q <= '0;
                  busy_q     <= 1'b0;
                  state_q    <= S_IDLE;
               end else begin
                  ack_cnt_q <= ack_cnt_q + 1'b1;
               end
            end
            S_RUN: begin
               slice_cnt_q <= slice_cnt_q + 1'b1;
               if (bus.sorter_in[8*idx_q +: 8] == 8'h00 || slice_cnt_q == SLICE_LAST) begin
                  op_out_q   <= {4'h0, id_q, OP_FINISH, 4'h0};
                  op_valid_q <= 1'b1;
                  cur_task_q <= '0;
                  state_q    <= S_FIN;
               end
            end
            S_FIN: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.host_ready = (state_q == S_IDLE) && !RST;
   assign bus.op_out     = op_out_q;
   assign bus.op_valid   = op_valid_q;
   assign bus.cur_task   = cur_task_q;
   assign bus.busy       = busy_q;
   assign bus.err_cnt    = err_cnt_q;
endmodule

// File: doc/task_dispatcher.md
# task_dispatcher

Scheduler-side counterpart of the per-task controllers. Each cycle it samples the N `{id, priority}` sorter words, picks the highest-priority ready task and issues an Execute op word on the shared op bus. It waits for that task's `exe_flag` acknowledge, runs a fixed time slice, then issues Finish. It also forwards host-originated op words (state change, priority, exe-hit) onto the same bus when idle.

## Interface
- `N_TASKS`, 8: number of task slots (1–16).
- `SLICE_CYCLES`, 1000: RUN duration in cycles (≥2).
- `ACK_TIMEOUT`, 64: max cycles to wait for `exe_flag` after Execute (≥1).

- `CLK`  in  1  system clock, all logic on posedge.
- `RST`  in  1  synchronous, active-high reset.
- `sorter_in`  in  8*N_TASKS  slot i at `[8i+7:8i]`; `[7:4]` task id, `[3:0]` priority; 8'h00 = not ready.
- `exe_flag`  in  N_TASKS  bit i = slot i execution acknowledge.
- `host_op`  in  16  host op word.
- `host_valid`  in  1  host op offered.
- `host_ready`  out  1  dispatcher accepts host op this cycle.
- `op_out`  out  16  op bus to tasks; `[11:8]` id, `[7:4]` opcode, `[3:0]` argument, `[15:12]` always 0.
- `op_valid`  out  1  one-cycle strobe; `op_out` meaningful only when high.
- `cur_task`  out  4  id of the task in ACK/RUN, else 0.
- `busy`  out  1  high in any state other than IDLE.
- `err_cnt`  out  8  ack-timeout count, saturating at 255.

## Operation
- Opcodes: 0001 Ready, 0010 Suspend, 0011 Wait, 0100 Kill, 0101 Set priority, 0110 Set exe hit, 0111 Execute, 1111 Finish.
- FSM states IDLE, SEL, EXE, ACK, RUN, FIN.
- **IDLE**
  - `host_ready` = 1.
  - If `host_valid`: register `op_out = host_op & 16'h0FFF`, `op_valid` = 1 for one cycle, stay in IDLE. The host takes precedence over dispatch.
  - Else if any slot is nonzero: go to SEL.
- **SEL** (1 cycle)
  - Winner = nonzero slot with the largest priority nibble; ties go to the lowest index.
  - Register winner index, id and priority, then go to EXE.
- **EXE** (1 cycle): `op_out = {4'h0, id, 4'h7, 4'h0}`, `op_valid` = 1, then go to ACK with the ack counter cleared.
- **ACK**
  - `exe_flag[idx]` = 1: go to RUN with the slice counter cleared.
  - Otherwise, when the ack counter reaches ACK_TIMEOUT-1: `err_cnt` += 1 (saturating) and go to IDLE. No Finish is issued.
- **RUN**
  - Slice counter increments each cycle.
  - Go to FIN when the counter equals SLICE_CYCLES-1, or when `sorter_in` slot idx reads 8'h00 (task left Ready). The early exit has precedence.
- **FIN** (1 cycle): `op_out = {4'h0, id, 4'hF, 4'h0}`, `op_valid` = 1, then go to IDLE.
- Counter widths are `$clog2` of their limit. `cur_task` equals the registered id in ACK and RUN.

## Timing
- Reset values: state IDLE, `op_out` = 0, `op_valid` = 0, `cur_task` = 0, `busy` = 0, `err_cnt` = 0, counters 0.
- `host_ready` is 0 while `RST` is high.
- All outputs are registered except `host_ready` (= state IDLE && !RST).
- Host op latency: `op_valid` rises the cycle after a `host_valid && host_ready` cycle. Back-to-back host ops give one op per cycle.
- Dispatch latency, from the IDLE cycle that detects a ready slot:
  - SEL: +1 cycle.
  - Execute strobe: +2.
  - RUN entered: the cycle after `exe_flag[idx]` is sampled high.
- Full slice: exactly SLICE_CYCLES cycles in RUN, with the Finish strobe on the next cycle.
- `host_valid` outside IDLE is held off (`host_ready` = 0), never dropped.
- `RST` mid-operation: next cycle is IDLE with reset values; no Finish is issued.
- Sorter changes during SEL→EXE are ignored; the winner is already registered.

## Configuration
- `DISPATCH_ROUND_ROBIN_EN` defined: priority ties are broken round-robin. Search starts at (last dispatched index + 1) mod N_TASKS. The last-dispatched index resets to N_TASKS-1.
- Not defined: ties go to the lowest index; no extra state.

## Test plan
- Host op 16'h0553 with `host_valid` in IDLE → next cycle `op_valid` = 1, `op_out` = 16'h0553. Host op 16'hF553 → `op_out` = 16'h0553.
- Slots 0 = 8'h52, 1 = 8'h37, 2 = 8'h55 → Execute 16'h0370. Slot 1 raises `exe_flag` → exactly SLICE_CYCLES RUN cycles, then 16'h03F0, `cur_task` = 3 during RUN.
- Ready slot, `exe_flag` never asserted → `err_cnt` = 1 after ACK_TIMEOUT cycles; no Finish strobe; back to IDLE.
- In RUN, winner's sorter word drops to 8'h00 at cycle 10 → Finish strobe on the following cycle.
- Slots 0 and 1 both 8'h54 / 8'h64, three dispatches:
  - Without the macro: all three go to id 5.
  - With `DISPATCH_ROUND_ROBIN_EN`: ids 5, 6, 5.
- `RST` pulsed in RUN → next cycle `op_valid` = 0, `busy` = 0, `err_cnt` = 0, `cur_task` = 0.
